// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned HZ_REG_W  = 5;
  // Slot rd field is sized for the widest supported REG_W; narrower indices are zero-extended.
  localparam int unsigned HZ_RD_MAX = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [HZ_RD_MAX-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // x0 is hard-wired zero, so a write to it never produces a dependency.
  function automatic logic slot_match(input slot_t s, input logic rd_used,
                                      input logic [HZ_RD_MAX-1:0] rs);
    return rd_used && s.valid && s.regwrite && (s.rd != '0) && (s.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)
      return FWD_MEM;
    else if (hit_mem)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// Three-deep scoreboard of in-flight register writes (EX -> MEM -> WB).
module hazard_slot_pipe
  import hazard_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  slot_t ex_next,
  output slot_t ex_slot,
  output slot_t mem_slot,
  output slot_t wb_slot
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_slot  <= SLOT_EMPTY;
      mem_slot <= SLOT_EMPTY;
      wb_slot  <= SLOT_EMPTY;
    end else begin
      ex_slot  <= ex_next;
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: stall/bubble generation and optional operand forwarding.
// Define HAZARD_FWD_EN for the load-use-only stall rule with registered fwd_a/fwd_b selects.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = HZ_REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  logic [HZ_RD_MAX-1:0] rs1_x, rs2_x, rd_x;
  slot_t ex_slot, mem_slot, wb_slot, ex_next;
  logic  hazard;
  logic  issue;

  assign rs1_x = HZ_RD_MAX'(id_rs1);
  assign rs2_x = HZ_RD_MAX'(id_rs2);
  assign rd_x  = HZ_RD_MAX'(id_rd);

  hazard_slot_pipe u_slots (
    .clock    (clock),
    .reset    (reset),
    .ex_next  (ex_next),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .wb_slot  (wb_slot)
  );

`ifdef HAZARD_FWD_EN
  logic m1_ex, m2_ex, m1_mem, m2_mem;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic unused_slot_bits;

  assign m1_ex  = slot_match(ex_slot,  id_use_rs1, rs1_x);
  assign m2_ex  = slot_match(ex_slot,  id_use_rs2, rs2_x);
  assign m1_mem = slot_match(mem_slot, id_use_rs1, rs1_x);
  assign m2_mem = slot_match(mem_slot, id_use_rs2, rs2_x);

  // Only a load still in EX cannot be forwarded in time.
  assign hazard = ex_slot.memread & (m1_ex | m2_ex);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (issue) begin
      fwd_a_q <= fwd_sel(m1_ex, m1_mem);
      fwd_b_q <= fwd_sel(m2_ex, m2_mem);
    end else begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
  assign unused_slot_bits = ^{mem_slot.memread, wb_slot};
`else
  logic m1_ex, m2_ex, m1_mem, m2_mem, m1_wb, m2_wb;
  logic unused_slot_bits;

  assign m1_ex  = slot_match(ex_slot,  id_use_rs1, rs1_x);
  assign m2_ex  = slot_match(ex_slot,  id_use_rs2, rs2_x);
  assign m1_mem = slot_match(mem_slot, id_use_rs1, rs1_x);
  assign m2_mem = slot_match(mem_slot, id_use_rs2, rs2_x);
  assign m1_wb  = slot_match(wb_slot,  id_use_rs1, rs1_x);
  assign m2_wb  = slot_match(wb_slot,  id_use_rs2, rs2_x);

  // The register file has no write-through, so WB still counts as in flight.
  assign hazard = m1_ex | m2_ex | m1_mem | m2_mem | m1_wb | m2_wb;

  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
  assign unused_slot_bits = ^{ex_slot.memread, mem_slot.memread, wb_slot.memread};
`endif

  assign stall  = !reset && id_valid && !flush && hazard;
  assign bubble = !reset && (stall || flush);
  assign issue  = id_valid && !stall && !flush;

  always_comb begin
    ex_next = SLOT_EMPTY;
    if (issue) begin
      ex_next.valid    = 1'b1;
      ex_next.rd       = rd_x;
      ex_next.regwrite = id_regwrite;
      ex_next.memread  = id_memread;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (stall && !(&stall_count))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl; follows HAZARD_FWD_EN when defined.
module tb_hazard_stall_ctrl;

  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic stall, bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_stall_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .stall       (stall),
    .bubble      (bubble),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per architectural register, the edge at which its latest writer entered EX.
  int cyc;
  int last_w[32];
  bit last_ld[32];
  int total;
  int exp_fa, exp_fb;

  function automatic bit src_hot(input logic [4:0] r, input logic u);
    int d;
    if (!u || r == 5'd0) return 1'b0;
    d = cyc - last_w[r];
    if (FWD) return (d == 0) && last_ld[r];
    return d <= 2;
  endfunction

  function automatic int src_sel(input logic [4:0] r, input logic u);
    int d;
    if (!FWD || !u || r == 5'd0) return 0;
    d = cyc - last_w[r];
    if (d == 0) return 2;
    if (d == 1) return 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    return !reset && id_valid && !flush &&
           (src_hot(id_rs1, id_use_rs1) || src_hot(id_rs2, id_use_rs2));
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc <= 0;
      total <= 0;
      exp_fa <= 0;
      exp_fb <= 0;
      for (int r = 0; r < 32; r++) begin
        last_w[r]  <= -100;
        last_ld[r] <= 1'b0;
      end
    end else begin
      if (m_stall()) total <= total + 1;
      if (id_valid && !m_stall() && !flush) begin
        exp_fa <= src_sel(id_rs1, id_use_rs1);
        exp_fb <= src_sel(id_rs2, id_use_rs2);
        if (id_regwrite && id_rd != 5'd0) begin
          last_w[id_rd]  <= cyc + 1;
          last_ld[id_rd] <= id_memread;
        end
      end else begin
        exp_fa <= 0;
        exp_fb <= 0;
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clock) begin
    chk("cmp_stall", stall, m_stall());
    chk("cmp_bubble", bubble, !reset && (m_stall() || flush));
    chk("cmp_fwd_a", fwd_a, exp_fa);
    chk("cmp_fwd_b", fwd_b, exp_fb);
    chk("cmp_stall_count", stall_count, (total > CMAX) ? CMAX : total);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one instruction in ID until it issues; returns stall cycles observed.
  task automatic send(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic mr, output int stalls);
    bit done;
    int i;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_valid = 1'b1;
    stalls = 0;
    done = 1'b0;
    i = 0;
    while (!done && i < 8) begin
      @(negedge clock);
      if (stall) stalls++;
      else done = 1'b1;
      i++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: stall still high after %0d cycles, required release", i);
    end
    @(posedge clock);
    #1;
    id_valid = 1'b0;
  endtask

  initial begin
    int s;
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_stall", stall, 0);
    chk("reset_fwd_a", fwd_a, 0);
    chk("reset_count", stall_count, 0);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // add x5,x1,x2 ; sub x6,x5,x3 ; or x7,x5,x5
    send(5'd1, 5'd2, 1, 1, 5'd5, 1, 0, s);
    chk("add_stalls", s, 0);
    send(5'd5, 5'd3, 1, 1, 5'd6, 1, 0, s);
    chk("sub_stalls", s, FWD ? 0 : 3);
    chk("sub_fwd_a", fwd_a, FWD ? 2 : 0);
    chk("sub_fwd_b", fwd_b, 0);
    chk("sub_count", stall_count, FWD ? 0 : 3);
    send(5'd5, 5'd5, 1, 1, 5'd7, 1, 0, s);
    chk("or_stalls", s, 0);
    chk("or_fwd_a", fwd_a, FWD ? 1 : 0);
    chk("or_fwd_b", fwd_b, FWD ? 1 : 0);

    // lw x6,0(x1) ; add x7,x6,x6
    idle(4);
    send(5'd1, 5'd0, 1, 0, 5'd6, 1, 1, s);
    send(5'd6, 5'd6, 1, 1, 5'd7, 1, 0, s);
    chk("lu_stalls", s, FWD ? 1 : 3);
    chk("lu_fwd_a", fwd_a, FWD ? 1 : 0);
    chk("lu_fwd_b", fwd_b, FWD ? 1 : 0);
    chk("lu_count", stall_count, FWD ? 1 : 6);

    // writer of x0 followed by a reader of x0
    idle(4);
    send(5'd1, 5'd2, 1, 1, 5'd0, 1, 1, s);
    send(5'd0, 5'd0, 1, 1, 5'd8, 1, 0, s);
    chk("x0_stalls", s, 0);
    chk("x0_fwd_a", fwd_a, 0);
    chk("x0_fwd_b", fwd_b, 0);

    // load-use stall condition coinciding with flush
    idle(4);
    send(5'd1, 5'd0, 1, 0, 5'd6, 1, 1, s);
    id_rs1 = 5'd6; id_rs2 = 5'd6; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd = 5'd7; id_regwrite = 1; id_memread = 0; id_valid = 1; flush = 1;
    @(negedge clock);
    chk("flush_stall", stall, 0);
    chk("flush_bubble", bubble, 1);
    @(posedge clock);
    #1;
    flush = 0;
    id_valid = 0;
    send(5'd7, 5'd0, 1, 0, 5'd9, 1, 0, s);
    chk("post_flush_stalls", s, 0);
    chk("post_flush_fwd_a", fwd_a, 0);

    // repeated dependent pairs drive the counter into saturation
    for (int k = 0; k < 8; k++) begin
      idle(4);
      send(5'd1, 5'd0, 1, 0, 5'd10, 1, FWD, s);
      send(5'd10, 5'd0, 1, 0, 5'd11, 1, 0, s);
      chk("sat_pair_stalls", s, FWD ? 1 : 3);
    end
    chk("sat_count", stall_count, CMAX);

    // reset asserted in the middle of a load-use stall
    idle(4);
    send(5'd1, 5'd0, 1, 0, 5'd6, 1, 1, s);
    id_rs1 = 5'd6; id_rs2 = 5'd6; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd = 5'd7; id_regwrite = 1; id_memread = 0; id_valid = 1;
    @(negedge clock);
    chk("pre_reset_stall", stall, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_stall", stall, 0);
    chk("mid_reset_bubble", bubble, 0);
    chk("mid_reset_fwd_a", fwd_a, 0);
    chk("mid_reset_fwd_b", fwd_b, 0);
    chk("mid_reset_count", stall_count, 0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    id_valid = 0;
    @(posedge clock);
    #1;
    send(5'd6, 5'd6, 1, 1, 5'd7, 1, 0, s);
    chk("after_reset_stalls", s, 0);
    chk("after_reset_fwd_a", fwd_a, 0);
    chk("after_reset_count", stall_count, 0);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
